// File: rtl/signed_mult9_kogge_stone_pkg.sv
// rtl/signed_mult9_kogge_stone_pkg.sv - shared widths and prefix-cell helper for the 9x9 signed multiplier
package signed_mult9_kogge_stone_pkg;

    localparam int MULT_W    = 9;
    localparam int PROD_W    = 2 * MULT_W;
    localparam int KS_LEVELS = 5;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Black cell: merges a higher (hi) group with the adjacent lower (lo) group.
    function automatic gp_t black_cell(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/signed_mult9_kogge_stone_adder.sv
// rtl/signed_mult9_kogge_stone_adder.sv - 18-bit Kogge-Stone prefix adder, carry-out discarded
module kogge_stone_adder_18
    import signed_mult9_kogge_stone_pkg::*;
(
    input  logic [PROD_W-1:0] a,
    input  logic [PROD_W-1:0] b,
    output logic [PROD_W-1:0] sum
);

    gp_t lvl [0:KS_LEVELS][0:PROD_W-1];

    always_comb begin
        for (int i = 0; i < PROD_W; i++) begin
            lvl[0][i].g = a[i] & b[i];
            lvl[0][i].p = a[i] ^ b[i];
        end
        // Span doubles each level: 1, 2, 4, 8, 16.
        for (int l = 1; l <= KS_LEVELS; l++) begin
            for (int i = 0; i < PROD_W; i++) begin
                if (i >= (1 << (l - 1)))
                    lvl[l][i] = black_cell(lvl[l-1][i], lvl[l-1][i - (1 << (l - 1))]);
                else
                    lvl[l][i] = lvl[l-1][i];
            end
        end
        sum[0] = lvl[0][0].p;
        for (int i = 1; i < PROD_W; i++)
            sum[i] = lvl[0][i].p ^ lvl[KS_LEVELS][i-1].g;
    end

endmodule

// File: rtl/signed_mult9_kogge_stone.sv
// rtl/signed_mult9_kogge_stone.sv - signed 9x9 Baugh-Wooley multiplier with carry-save reduction and Kogge-Stone final add
module signed_mult9_kogge_stone
    import signed_mult9_kogge_stone_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   S,
    output logic [2*WIDTH-1:0]   S_q
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] rows [0:WIDTH];
    logic [PW-1:0] cs_sum;
    logic [PW-1:0] cs_carry;

    // Partial products where exactly one operand bit is a sign bit are inverted;
    // the extra row adds the 2^WIDTH and 2^(2*WIDTH-1) correction constants.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            rows[i] = '0;
            for (int j = 0; j < WIDTH; j++) begin
                if ((i == WIDTH - 1) != (j == WIDTH - 1))
                    rows[i][i + j] = ~(A[j] & B[i]);
                else
                    rows[i][i + j] = A[j] & B[i];
            end
        end
        rows[WIDTH]         = '0;
        rows[WIDTH][WIDTH]  = 1'b1;
        rows[WIDTH][PW-1]   = 1'b1;
    end

    // Carry-save array: each step folds one more row through a line of full adders.
    always_comb begin
        logic [PW-1:0] s_n;
        logic [PW-1:0] c_n;
        cs_sum   = rows[0];
        cs_carry = rows[1];
        for (int r = 2; r <= WIDTH; r++) begin
            s_n      = cs_sum ^ cs_carry ^ rows[r];
            c_n      = (cs_sum & cs_carry) | (cs_sum & rows[r]) | (cs_carry & rows[r]);
            cs_sum   = s_n;
            cs_carry = {c_n[PW-2:0], 1'b0};
        end
    end

    kogge_stone_adder_18 u_final_add (
        .a   (cs_sum),
        .b   (cs_carry),
        .sum (S)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            S_q <= '0;
        else
            S_q <= S;
    end

endmodule

// File: tb/tb_signed_mult9_kogge_stone.sv
// tb/tb_signed_mult9_kogge_stone.sv - scoreboard bench for the signed 9x9 multiplier
module tb_signed_mult9_kogge_stone;

    logic        clk;
    logic        rst_n;
    logic [8:0]  A;
    logic [8:0]  B;
    logic [17:0] S;
    logic [17:0] S_q;

    int n_vec;
    int n_err;
    logic [17:0] exp_q [$];

    signed_mult9_kogge_stone dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .S     (S),
        .S_q   (S_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] golden(input logic signed [8:0] a, input logic signed [8:0] b);
        int p;
        p = int'(a) * int'(b);
        return p[17:0];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        A = 9'd7;
        B = 9'h1F8;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (S_q !== 18'h0) begin
                n_err++;
                $display("FAIL reset_sq cycle %0d: got %h want %h", k, S_q, 18'h0);
            end
            A = 9'($urandom);
            B = 9'($urandom);
        end
        A = 9'd7;
        B = 9'h1F8;
        #1;
        n_vec++;
        if (S !== 18'h3FFC8) begin
            n_err++;
            $display("FAIL reset_comb_s: got %h want %h", S, 18'h3FFC8);
        end
    endtask

    task automatic test_directed();
        int          da [9] = '{0, 1, -1, -256, 255, -256, 100, -3, -1};
        int          db [9] = '{-137, -1, -1, -256, 255, 255, -3, 100, -256};
        logic [17:0] de [9] = '{18'h00000, 18'h3FFFF, 18'h00001, 18'h10000, 18'h0FE01,
                                18'h30100, 18'h3FED4, 18'h3FED4, 18'h00100};
        logic [17:0] e;
        for (int i = 0; i < 9; i++) begin
            A = 9'(da[i]);
            B = 9'(db[i]);
            exp_q.push_back(de[i]);
            #1;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL directed_%0d: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (S !== e) begin
                    n_err++;
                    $display("FAIL directed_%0d A=%0d B=%0d: got %h want %h", i, da[i], db[i], S, e);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [17:0] e;
        for (int i = 0; i < 60; i++) begin
            A = 9'($urandom);
            B = 9'($urandom);
            exp_q.push_back(golden(A, B));
            #10;
            n_vec++;
            e = exp_q.pop_front();
            if (S !== e) begin
                n_err++;
                $display("FAIL random_%0d A=%h B=%h: got %h want %h", i, A, B, S, e);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [17:0] e;
        for (int i = 0; i < 512; i++) begin
            for (int j = 0; j < 512; j++) begin
                A = 9'(i);
                B = 9'(j);
                exp_q.push_back(golden(A, B));
                #1;
                n_vec++;
                e = exp_q.pop_front();
                if (S !== e) begin
                    n_err++;
                    $display("FAIL exhaustive A=%h B=%h: got %h want %h", A, B, S, e);
                end
            end
        end
    endtask

    task automatic test_register();
        @(negedge clk);
        rst_n = 1'b1;
        A = 9'd7;
        B = 9'h1F8;
        exp_q.push_back(18'h3FFC8);
        #1;
        n_vec++;
        if (S !== 18'h3FFC8) begin
            n_err++;
            $display("FAIL register_s_now: got %h want %h", S, 18'h3FFC8);
        end
        n_vec++;
        if (S_q !== 18'h0) begin
            n_err++;
            $display("FAIL register_sq_before_edge: got %h want %h", S_q, 18'h0);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (S_q !== exp_q.pop_front()) begin
            n_err++;
            $display("FAIL register_sq_after_edge: got %h want %h", S_q, 18'h3FFC8);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] e;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            A = 9'($urandom);
            B = 9'($urandom);
            exp_q.push_back(golden(A, B));
            @(posedge clk);
            #1;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL back_to_back_%0d: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (S_q !== e) begin
                    n_err++;
                    $display("FAIL back_to_back_%0d: got %h want %h", i, S_q, e);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        A = 9'd7;
        B = 9'h1F8;
        @(posedge clk);
        #1;
        n_vec++;
        if (S_q !== 18'h3FFC8) begin
            n_err++;
            $display("FAIL async_pre_sq: got %h want %h", S_q, 18'h3FFC8);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (S_q !== 18'h0) begin
            n_err++;
            $display("FAIL async_clear_sq: got %h want %h", S_q, 18'h0);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (S_q !== 18'h0) begin
            n_err++;
            $display("FAIL async_hold_sq: got %h want %h", S_q, 18'h0);
        end
        n_vec++;
        if (S !== 18'h3FFC8) begin
            n_err++;
            $display("FAIL async_comb_s: got %h want %h", S, 18'h3FFC8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (S_q !== 18'h3FFC8) begin
            n_err++;
            $display("FAIL async_resume_sq: got %h want %h", S_q, 18'h3FFC8);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        A = '0;
        B = '0;
        test_reset();
        test_directed();
        test_random();
        test_exhaustive();
        test_register();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
